// File: rtl/adder_arbiter.sv
// Round-robin scheduler sharing one external saturating adder among NREQ requesters.
// One operation in flight: IDLE accepts, EXEC captures the adder result, RESP returns it.
module adder_arbiter #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       resp_valid,
   input  logic [NREQ-1:0]       resp_ready,
   output logic [WIDTH-1:0]      resp_data,
   output logic                  resp_zr,
   output logic                  resp_neg,
   output logic                  resp_ov,
   output logic                  busy,
   output logic [WIDTH-1:0]      add_in1,
   output logic [WIDTH-1:0]      add_in2,
   input  logic [WIDTH-1:0]      add_out,
   input  logic                  add_zr,
   input  logic                  add_neg,
   input  logic                  add_ov
);

   localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]   gnt_id_q, gnt_id_d;
   logic [WIDTH-1:0] add_in1_q, add_in1_d;
   logic [WIDTH-1:0] add_in2_q, add_in2_d;
   logic [WIDTH-1:0] resp_data_q, resp_data_d;
   logic             resp_zr_q, resp_zr_d;
   logic             resp_neg_q, resp_neg_d;
   logic             resp_ov_q, resp_ov_d;
   logic [NREQ-1:0]  resp_valid_q, resp_valid_d;
   logic             busy_q, busy_d;

   logic             found_c;
   logic [IDW-1:0]   grant_c;
   logic [IDW:0]     idx_c;
   logic [WIDTH-1:0] a_sel_c;
   logic [WIDTH-1:0] b_sel_c;
   logic [NREQ-1:0]  req_ready_c;

   // Search downward so the requester closest to rr_ptr (smallest offset) wins.
   always_comb begin
      found_c = 1'b0;
      grant_c = '0;
      idx_c   = '0;
      for (int k = int'(NREQ) - 1; k >= 0; k--) begin
         idx_c = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         if (idx_c >= (IDW+1)'(NREQ)) idx_c = idx_c - (IDW+1)'(NREQ);
         if (req_valid[idx_c[IDW-1:0]]) begin
            found_c = 1'b1;
            grant_c = idx_c[IDW-1:0];
         end
      end
   end

   // Operand mux for the granted requester.
   always_comb begin
      a_sel_c = '0;
      b_sel_c = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant_c == IDW'(i)) begin
            a_sel_c = req_a[i*WIDTH +: WIDTH];
            b_sel_c = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   // Next-state and datapath control.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      gnt_id_d     = gnt_id_q;
      add_in1_d    = add_in1_q;
      add_in2_d    = add_in2_q;
      resp_data_d  = resp_data_q;
      resp_zr_d    = resp_zr_q;
      resp_neg_d   = resp_neg_q;
      resp_ov_d    = resp_ov_q;
      resp_valid_d = resp_valid_q;
      busy_d       = busy_q;
      req_ready_c  = '0;
      case (state_q)
         S_IDLE: begin
            if (found_c) begin
               req_ready_c = NREQ'(1) << grant_c;
               add_in1_d   = a_sel_c;
               add_in2_d   = b_sel_c;
               gnt_id_d    = grant_c;
               state_d     = S_EXEC;
               busy_d      = 1'b1;
            end
         end
         S_EXEC: begin
            resp_data_d  = add_out;
            resp_zr_d    = add_zr;
            resp_neg_d   = add_neg;
            resp_ov_d    = add_ov;
            resp_valid_d = NREQ'(1) << gnt_id_q;
            state_d      = S_RESP;
         end
         S_RESP: begin
            if (resp_ready[gnt_id_q]) begin
               resp_valid_d = '0;
               busy_d       = 1'b0;
               state_d      = S_IDLE;
               rr_ptr_d     = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + IDW'(1);
            end
         end
         default: begin
            resp_valid_d = '0;
            busy_d       = 1'b0;
            state_d      = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         rr_ptr_q     <= '0;
         gnt_id_q     <= '0;
         add_in1_q    <= '0;
         add_in2_q    <= '0;
         resp_data_q  <= '0;
         resp_zr_q    <= 1'b0;
         resp_neg_q   <= 1'b0;
         resp_ov_q    <= 1'b0;
         resp_valid_q <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         gnt_id_q     <= gnt_id_d;
         add_in1_q    <= add_in1_d;
         add_in2_q    <= add_in2_d;
         resp_data_q  <= resp_data_d;
         resp_zr_q    <= resp_zr_d;
         resp_neg_q   <= resp_neg_d;
         resp_ov_q    <= resp_ov_d;
         resp_valid_q <= resp_valid_d;
         busy_q       <= busy_d;
      end
   end

   // Accept is combinational but forced low while reset is asserted.
   assign req_ready  = rst_n ? req_ready_c : '0;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_zr    = resp_zr_q;
   assign resp_neg   = resp_neg_q;
   assign resp_ov    = resp_ov_q;
   assign busy       = busy_q;
   assign add_in1    = add_in1_q;
   assign add_in2    = add_in2_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a behavioural 16-bit signed saturating adder.
module tb_adder_arbiter;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned WIDTH = 16;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ-1:0]       resp_valid;
   logic [NREQ-1:0]       resp_ready;
   logic [WIDTH-1:0]      resp_data;
   logic                  resp_zr, resp_neg, resp_ov, busy;
   logic [WIDTH-1:0]      add_in1, add_in2, add_out;
   logic                  add_zr, add_neg, add_ov;
   logic [WIDTH:0]        sum17;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_zr(resp_zr), .resp_neg(resp_neg), .resp_ov(resp_ov), .busy(busy),
      .add_in1(add_in1), .add_in2(add_in2), .add_out(add_out),
      .add_zr(add_zr), .add_neg(add_neg), .add_ov(add_ov)
   );

   // External saturating adder.
   always_comb begin
      sum17   = {add_in1[WIDTH-1], add_in1} + {add_in2[WIDTH-1], add_in2};
      add_ov  = sum17[WIDTH] != sum17[WIDTH-1];
      add_out = add_ov ? (sum17[WIDTH] ? 16'h8000 : 16'h7FFF) : sum17[WIDTH-1:0];
      add_zr  = (add_out == '0);
      add_neg = add_out[WIDTH-1];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      req_valid  = '0;
      resp_ready = '0;
      req_a      = '0;
      req_b      = '0;
      #12;
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = 4'b1111;
      #3;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
      checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL reset_resp_valid got %b exp 0000", resp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if ({add_in1, add_in2} !== 32'h0) begin errors++; $display("FAIL reset_add_in got %h exp 0", {add_in1, add_in2}); end
      checks++; if ({resp_data, resp_zr, resp_neg, resp_ov} !== 19'h0) begin errors++; $display("FAIL reset_resp got %h exp 0", {resp_data, resp_zr, resp_neg, resp_ov}); end
      do_reset();
   endtask

   task automatic test_single();
      req_a[15:0] = 16'h0003;
      req_b[15:0] = 16'h0004;
      resp_ready  = 4'b1111;
      req_valid   = 4'b0001;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
      step();
      req_valid = '0;
      checks++; if ({add_in1, add_in2} !== {16'h0003, 16'h0004}) begin errors++; $display("FAIL single_add_in got %h exp 00030004", {add_in1, add_in2}); end
      checks++; if ({busy, resp_valid, req_ready} !== 9'b1_0000_0000) begin errors++; $display("FAIL single_exec got %b exp 100000000", {busy, resp_valid, req_ready}); end
      step();
      checks++; if (resp_valid !== 4'b0001) begin errors++; $display("FAIL single_resp_valid got %b exp 0001", resp_valid); end
      checks++; if ({resp_data, resp_zr, resp_neg, resp_ov} !== {16'h0007, 3'b000}) begin errors++; $display("FAIL single_data got %h exp %h", {resp_data, resp_zr, resp_neg, resp_ov}, {16'h0007, 3'b000}); end
      step();
      checks++; if ({busy, resp_valid} !== 5'b0) begin errors++; $display("FAIL single_idle got %b exp 00000", {busy, resp_valid}); end
   endtask

   task automatic test_round_robin();
      logic [3:0]  exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [15:0] exp_sum [5] = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0101};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         req_a[i*16 +: 16] = 16'(16'h0100 * (i + 1));
         req_b[i*16 +: 16] = 16'(i + 1);
      end
      resp_ready = 4'b1111;
      req_valid  = 4'b1111;
      #1;
      for (int n = 0; n < 5; n++) begin
         checks++; if (req_ready !== exp_gnt[n]) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", n, req_ready, exp_gnt[n]); end
         step();
         step();
         checks++; if (resp_valid !== exp_gnt[n]) begin errors++; $display("FAIL rr_resp%0d got %b exp %b", n, resp_valid, exp_gnt[n]); end
         checks++; if (resp_data !== exp_sum[n]) begin errors++; $display("FAIL rr_data%0d got %h exp %h", n, resp_data, exp_sum[n]); end
         step();
      end
      req_valid = '0;
      step();
   endtask

   task automatic test_backpressure();
      req_a[48 +: 16] = 16'h0010;
      req_b[48 +: 16] = 16'h0020;
      resp_ready = 4'b0000;
      req_valid  = 4'b1000;
      #1;
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_grant got %b exp 1000", req_ready); end
      step();
      step();
      resp_ready = 4'b0111;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if ({resp_valid, resp_data, req_ready, busy} !== {4'b1000, 16'h0030, 4'b0000, 1'b1}) begin
            errors++; $display("FAIL bp_hold%0d got %h exp %h", c, {resp_valid, resp_data, req_ready, busy}, {4'b1000, 16'h0030, 4'b0000, 1'b1});
         end
         step();
      end
      req_valid  = '0;
      resp_ready = 4'b1000;
      step();
      checks++; if ({busy, resp_valid} !== 5'b0) begin errors++; $display("FAIL bp_release got %b exp 00000", {busy, resp_valid}); end
   endtask

   task automatic test_flags();
      logic [15:0] va [3] = '{16'h7000, 16'h0001, 16'h8000};
      logic [15:0] vb [3] = '{16'h7000, 16'hFFFF, 16'h0001};
      logic [18:0] ex [3] = '{{16'h7FFF, 3'b001}, {16'h0000, 3'b100}, {16'h8001, 3'b010}};
      resp_ready = 4'b1111;
      for (int n = 0; n < 3; n++) begin
         req_a[15:0] = va[n];
         req_b[15:0] = vb[n];
         req_valid   = 4'b0001;
         #1;
         checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL flags_grant%0d got %b exp 0001", n, req_ready); end
         step();
         req_valid = '0;
         step();
         checks++; if ({resp_data, resp_zr, resp_neg, resp_ov} !== ex[n]) begin errors++; $display("FAIL flags%0d got %h exp %h", n, {resp_data, resp_zr, resp_neg, resp_ov}, ex[n]); end
         step();
      end
   endtask

   task automatic test_reset_exec();
      req_a[16 +: 16] = 16'h1111;
      req_b[16 +: 16] = 16'h2222;
      resp_ready = 4'b1111;
      req_valid  = 4'b0010;
      step();
      req_valid = '0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rexec_busy got %b exp 1", busy); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if ({busy, resp_valid, add_in1, add_in2} !== 37'h0) begin errors++; $display("FAIL rexec_clear got %h exp 0", {busy, resp_valid, add_in1, add_in2}); end
      #4;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         checks++; if ({busy, resp_valid} !== 5'b0) begin errors++; $display("FAIL rexec_noresp%0d got %b exp 00000", c, {busy, resp_valid}); end
      end
      req_valid = 4'b1111;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rexec_ptr got %b exp 0001", req_ready); end
      req_valid = '0;
      step();
   endtask

   task automatic test_drop();
      resp_ready = 4'b1111;
      req_valid  = 4'b0110;
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL drop_grant got %b exp 0010", req_ready); end
      step();
      req_valid = '0;
      step();
      checks++; if (resp_valid !== 4'b0010) begin errors++; $display("FAIL drop_resp got %b exp 0010", resp_valid); end
      for (int c = 0; c < 6; c++) begin
         step();
         checks++; if ({req_ready, resp_valid, busy} !== 9'b0) begin errors++; $display("FAIL drop_idle%0d got %b exp 000000000", c, {req_ready, resp_valid, busy}); end
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = '0;
      resp_ready = '0;
      req_a      = '0;
      req_b      = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_flags();
      test_reset_exec();
      test_drop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
